// File: rtl/lift_pkg.sv
// Shared constants and types for the lift call scheduler.
package lift_pkg;

    // Motor command codes
    localparam logic [1:0] MOT_STOP = 2'b00;
    localparam logic [1:0] MOT_UP   = 2'b01;
    localparam logic [1:0] MOT_DOWN = 2'b10;

    // Scheduler states
    typedef enum logic [2:0] {
        ST_IDLE,
        ST_MOVE_UP,
        ST_MOVE_DOWN,
        ST_DWELL,
        ST_OVERLOAD,
        ST_FAULT
    } state_t;

    // Display codes: DISP_P is the code for floor 1; floor n shows DISP_P + n - 1
    localparam logic [2:0] DISP_OFF = 3'b000;
    localparam logic [2:0] DISP_S   = 3'b101;
    localparam logic [2:0] DISP_P   = 3'b001;

    // Travel direction
    localparam logic DIR_UP   = 1'b0;
    localparam logic DIR_DOWN = 1'b1;

    // Index of the lowest set limit switch; holds the previous floor between floors
    function automatic logic [1:0] lowest_floor(input logic [3:0] v, input logic [1:0] hold);
        logic [1:0] f;
        f = hold;
        for (int i = 3; i >= 0; i--) begin
            if (v[i]) f = 2'(i);
        end
        return f;
    endfunction

endpackage

// File: rtl/lift_call_picker.sv
// SCAN direction picker: summarises pending calls relative to the current floor.
module lift_call_picker
    import lift_pkg::*;
#(
    parameter int NUM_FLOORS = 4
) (
    input  logic [NUM_FLOORS-1:0] pending_i,
    input  logic [1:0]            cur_floor_i,
    input  logic                  dir_i,
    output logic                  any_above_o,
    output logic                  any_below_o,
    output logic                  here_o,
    output logic                  next_dir_o
);

    // Split pending calls into above / below / at the current floor
    always_comb begin
        any_above_o = 1'b0;
        any_below_o = 1'b0;
        here_o      = 1'b0;
        for (int i = 0; i < NUM_FLOORS; i++) begin
            if (i > int'(cur_floor_i)) any_above_o = any_above_o | pending_i[i];
            if (i < int'(cur_floor_i)) any_below_o = any_below_o | pending_i[i];
            if (i == int'(cur_floor_i)) here_o     = pending_i[i];
        end
    end

    // Keep going the current way while there is work ahead; reverse only when needed
    always_comb begin
        if (any_above_o && (dir_i == DIR_UP || !any_below_o)) next_dir_o = DIR_UP;
        else if (any_below_o)                                  next_dir_o = DIR_DOWN;
        else                                                   next_dir_o = dir_i;
    end

endmodule

// File: rtl/lift_call_scheduler.sv
// Lift call scheduler and motor sequencer.
// Optional watchdog (FAULT state, move timeout) enabled by defining LIFT_WATCHDOG_EN.
module lift_call_scheduler
    import lift_pkg::*;
#(
    parameter int NUM_FLOORS   = 4,
    parameter int DWELL_CYCLES = 1000,
    parameter int MOVE_TIMEOUT = 50000000
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [NUM_FLOORS-1:0] call_btn,
    input  logic [NUM_FLOORS-1:0] fc,
    input  logic                  sp,
    output logic [1:0]            motores,
    output logic [1:0]            cur_floor,
    output logic [NUM_FLOORS-1:0] pending,
    output logic                  busy,
    output logic                  fault,
    output logic [2:0]            disp_code
);

    localparam int CW = (DWELL_CYCLES > 1) ? $clog2(DWELL_CYCLES) : 1;

    state_t                state_q, state_d;
    logic                  dir_q, dir_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic [NUM_FLOORS-1:0] pending_q, pending_d;
    logic [NUM_FLOORS-1:0] btn_q;
    logic [1:0]            cur_floor_q, cur_floor_d;
    logic [1:0]            motores_q, motores_d;
    logic [2:0]            disp_q, disp_d;
    logic                  busy_q;

    logic [NUM_FLOORS-1:0] rise, set_mask, clr_mask, cur_oh, arr;
    logic [3:0]            fc_ext;
    logic                  any_above, any_below, here, next_dir;

`ifdef LIFT_WATCHDOG_EN
    logic [31:0]           wd_q, wd_d;
    logic [NUM_FLOORS-1:0] fc_q;
    logic                  fault_q;
    logic                  wd_expired;
`else
    logic                  unused_timeout;
    assign unused_timeout = (MOVE_TIMEOUT != 0);
`endif

    assign rise = call_btn & ~btn_q;

    // Zero-extend the limit switches and decode the current floor as a one-hot mask
    always_comb begin
        fc_ext = '0;
        fc_ext[NUM_FLOORS-1:0] = fc;
        cur_oh = '0;
        for (int i = 0; i < NUM_FLOORS; i++) cur_oh[i] = (int'(cur_floor_q) == i);
    end

    lift_call_picker #(.NUM_FLOORS(NUM_FLOORS)) u_picker (
        .pending_i   (pending_q),
        .cur_floor_i (cur_floor_q),
        .dir_i       (dir_q),
        .any_above_o (any_above),
        .any_below_o (any_below),
        .here_o      (here),
        .next_dir_o  (next_dir)
    );

    assign arr = fc & pending_q;

`ifdef LIFT_WATCHDOG_EN
    // Time out only while the switches are steady; a switch change proves motion
    assign wd_expired = (fc == fc_q) && (wd_q == 32'(MOVE_TIMEOUT - 1));
`endif

    // Next-state, pending-call and output decode
    always_comb begin
        state_d     = state_q;
        dir_d       = dir_q;
        cnt_d       = cnt_q;
        set_mask    = rise;
        clr_mask    = '0;
        cur_floor_d = lowest_floor(fc_ext, cur_floor_q);
`ifdef LIFT_WATCHDOG_EN
        wd_d        = '0;
`endif
        case (state_q)
            ST_IDLE: begin
                if (sp) begin
                    state_d = ST_OVERLOAD;
                end else if (here) begin
                    state_d  = ST_DWELL;
                    cnt_d    = '0;
                    clr_mask = cur_oh;
                end else if (any_above || any_below) begin
                    dir_d   = next_dir;
                    state_d = (next_dir == DIR_UP) ? ST_MOVE_UP : ST_MOVE_DOWN;
                end
            end
            ST_MOVE_UP, ST_MOVE_DOWN: begin
`ifdef LIFT_WATCHDOG_EN
                wd_d = (fc != fc_q) ? 32'd0 : wd_q + 32'd1;
`endif
                // Stop at a pending floor, or at the end of travel no matter what
                if ((|arr) ||
                    (state_q == ST_MOVE_UP   && fc[NUM_FLOORS-1]) ||
                    (state_q == ST_MOVE_DOWN && fc[0])) begin
                    state_d  = ST_DWELL;
                    cnt_d    = '0;
                    clr_mask = arr;
`ifdef LIFT_WATCHDOG_EN
                end else if (wd_expired) begin
                    state_d = ST_FAULT;
`endif
                end
            end
            ST_DWELL: begin
                if (sp) begin
                    state_d = ST_OVERLOAD;
                end else if (|(rise & cur_oh)) begin
                    // A call for the floor we are at just holds the doors open longer
                    cnt_d    = '0;
                    set_mask = rise & ~cur_oh;
                end else if (cnt_q == CW'(DWELL_CYCLES - 1)) begin
                    state_d = ST_IDLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_OVERLOAD: begin
                if (!sp) begin
                    state_d = ST_DWELL;
                    cnt_d   = '0;
                end
            end
            ST_FAULT: state_d = ST_FAULT;
            default:  state_d = ST_IDLE;
        endcase

        pending_d = (pending_q | set_mask) & ~clr_mask;

        case (state_d)
            ST_MOVE_UP:   motores_d = MOT_UP;
            ST_MOVE_DOWN: motores_d = MOT_DOWN;
            default:      motores_d = MOT_STOP;
        endcase

        if (state_d == ST_FAULT)         disp_d = DISP_OFF;
        else if (state_d == ST_OVERLOAD) disp_d = DISP_S;
        else                             disp_d = DISP_P + {1'b0, cur_floor_d};
    end

    // State and registered outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            dir_q       <= DIR_UP;
            cnt_q       <= '0;
            pending_q   <= '0;
            btn_q       <= '0;
            cur_floor_q <= 2'd0;
            motores_q   <= MOT_STOP;
            disp_q      <= DISP_P;
            busy_q      <= 1'b0;
`ifdef LIFT_WATCHDOG_EN
            wd_q        <= '0;
            fc_q        <= '0;
            fault_q     <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            dir_q       <= dir_d;
            cnt_q       <= cnt_d;
            pending_q   <= pending_d;
            btn_q       <= call_btn;
            cur_floor_q <= cur_floor_d;
            motores_q   <= motores_d;
            disp_q      <= disp_d;
            busy_q      <= (state_d != ST_IDLE);
`ifdef LIFT_WATCHDOG_EN
            wd_q        <= wd_d;
            fc_q        <= fc;
            fault_q     <= (state_d == ST_FAULT);
`endif
        end
    end

    assign motores   = motores_q;
    assign cur_floor = cur_floor_q;
    assign pending   = pending_q;
    assign busy      = busy_q;
    assign disp_code = disp_q;
`ifdef LIFT_WATCHDOG_EN
    assign fault     = fault_q;
`else
    assign fault     = 1'b0;
`endif

endmodule

// File: tb/tb_lift_call_scheduler.sv
// Directed bench for lift_call_scheduler with an arrival-floor scoreboard.
module tb_lift_call_scheduler;

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] call_btn;
    logic [3:0] fc;
    logic       sp;
    logic [1:0] motores;
    logic [1:0] cur_floor;
    logic [3:0] pending;
    logic       busy;
    logic       fault;
    logic [2:0] disp_code;

    int total = 0;
    int bad   = 0;
    int exp_q[$];

    lift_call_scheduler #(
        .NUM_FLOORS   (4),
        .DWELL_CYCLES (1000),
        .MOVE_TIMEOUT (100)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .call_btn  (call_btn),
        .fc        (fc),
        .sp        (sp),
        .motores   (motores),
        .cur_floor (cur_floor),
        .pending   (pending),
        .busy      (busy),
        .fault     (fault),
        .disp_code (disp_code)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic press(input logic [3:0] b);
        call_btn = b;
        tick();
        call_btn = 4'b0000;
    endtask

    // Drive the limit switches to a floor and check the stop against the scoreboard
    task automatic arrive(input logic [3:0] f, input string tag);
        int e;
        fc = f;
        tick();
        total++;
        assert (exp_q.size() > 0) else begin
            bad++;
            $error("FAIL %s observed=empty_queue expected=arrival", tag);
        end
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk({tag, "_floor"}, 32'(cur_floor), 32'(e));
            chk({tag, "_stop"}, 32'(motores), 32'd0);
            chk({tag, "_disp"}, 32'(disp_code), 32'(e + 1));
        end
    endtask

    initial begin
        reset = 1'b1; call_btn = 4'b0000; fc = 4'b0001; sp = 1'b0;
        ticks(2);
        chk("rst_mot",  32'(motores),   32'd0);
        chk("rst_cur",  32'(cur_floor), 32'd0);
        chk("rst_pend", 32'(pending),   32'd0);
        chk("rst_busy", 32'(busy),      32'd0);
        chk("rst_flt",  32'(fault),     32'd0);
        chk("rst_disp", 32'(disp_code), 32'd1);
        reset = 1'b0;

        // Floor 1 -> floor 3, exact dwell length
        call_btn = 4'b0100;
        tick();
        chk("t1_pend", 32'(pending), 32'h4);
        chk("t1_idle", 32'(motores), 32'd0);
        call_btn = 4'b0100;
        tick();
        chk("t1_up", 32'(motores), 32'd1);
        call_btn = 4'b0000;
        exp_q.push_back(2);
        fc = 4'b0000; tick();
        chk("t1_hold_cur", 32'(cur_floor), 32'd0);
        fc = 4'b0010; tick();
        chk("t1_pass2", 32'(motores), 32'd1);
        chk("t1_cur1",  32'(cur_floor), 32'd1);
        arrive(4'b0100, "t1_arr");
        chk("t1_clr", 32'(pending), 32'd0);
        ticks(999);
        chk("t1_dwell_busy", 32'(busy), 32'd1);
        tick();
        chk("t1_dwell_done", 32'(busy), 32'd0);

        // At floor 3 heading up, calls 1 and 4: keep going up first
        press(4'b1001);
        chk("t3_pend", 32'(pending), 32'h9);
        tick();
        chk("t3_up", 32'(motores), 32'd1);
        exp_q.push_back(3);
        fc = 4'b0000; tick();
        arrive(4'b1000, "t3_arr4");
        chk("t3_pend1", 32'(pending), 32'h1);
        ticks(1000);
        chk("t3_idle", 32'(busy), 32'd0);
        tick();
        chk("t3_down", 32'(motores), 32'd2);
        exp_q.push_back(0);
        fc = 4'b0000; tick();
        fc = 4'b0100; tick();
        chk("t3_pass3", 32'(motores), 32'd2);
        fc = 4'b0010; tick();
        arrive(4'b0001, "t3_arr1");
        ticks(1000);

        // Intermediate call on the way up is served first
        press(4'b1000);
        exp_q.push_back(3);
        tick();
        chk("t2_up", 32'(motores), 32'd1);
        fc = 4'b0000; tick();
        press(4'b0010);
        exp_q.push_front(1);
        chk("t2_pend", 32'(pending), 32'ha);
        arrive(4'b0010, "t2_arr2");
        chk("t2_pend4", 32'(pending), 32'h8);
        ticks(1000);
        tick();
        chk("t2_up_again", 32'(motores), 32'd1);
        fc = 4'b0000; tick();
        fc = 4'b0100; tick();
        chk("t2_pass3", 32'(motores), 32'd1);
        arrive(4'b1000, "t2_arr4");
        ticks(1000);

        // Overload during dwell at floor 2
        press(4'b0010);
        exp_q.push_back(1);
        tick();
        chk("t4_down", 32'(motores), 32'd2);
        fc = 4'b0000; tick();
        fc = 4'b0100; tick();
        arrive(4'b0010, "t4_arr2");
        ticks(5);
        sp = 1'b1; tick();
        chk("t4_ovl_disp", 32'(disp_code), 32'd5);
        chk("t4_ovl_mot",  32'(motores),   32'd0);
        press(4'b1000);
        chk("t4_ovl_latch", 32'(pending), 32'h8);
        ticks(3);
        chk("t4_ovl_still", 32'(motores), 32'd0);
        sp = 1'b0; tick();
        chk("t4_dwell_disp", 32'(disp_code), 32'd2);
        ticks(500);
        press(4'b0010);
        chk("t4_restart_nopend", 32'(pending), 32'h8);
        ticks(999);
        chk("t4_dwell_busy", 32'(busy), 32'd1);
        tick();
        chk("t4_dwell_done", 32'(busy), 32'd0);
        tick();
        chk("t4_up", 32'(motores), 32'd1);
        exp_q.push_back(3);
        fc = 4'b0000; tick();
        fc = 4'b0100; tick();
        arrive(4'b1000, "t4_arr4");
        ticks(1000);

        // Reset while moving down
        press(4'b0001);
        tick();
        chk("t5_down", 32'(motores), 32'd2);
        fc = 4'b0000; tick();
        press(4'b0010);
        chk("t5_pend", 32'(pending), 32'h3);
        reset = 1'b1; tick();
        reset = 1'b0;
        exp_q.delete();
        chk("t5_mot",  32'(motores),   32'd0);
        chk("t5_pend0", 32'(pending),  32'd0);
        chk("t5_cur",  32'(cur_floor), 32'd0);
        chk("t5_busy", 32'(busy),      32'd0);
        chk("t5_disp", 32'(disp_code), 32'd1);
        tick();
        chk("t5_stay_idle", 32'(busy), 32'd0);

`ifdef LIFT_WATCHDOG_EN
        // Watchdog: move with no limit-switch activity
        press(4'b0100);
        tick();
        chk("t6_up", 32'(motores), 32'd1);
        ticks(99);
        chk("t6_pre_flt", 32'(fault),   32'd0);
        chk("t6_pre_mot", 32'(motores), 32'd1);
        tick();
        chk("t6_flt",  32'(fault),     32'd1);
        chk("t6_mot",  32'(motores),   32'd0);
        chk("t6_disp", 32'(disp_code), 32'd0);
        press(4'b1000);
        ticks(5);
        chk("t6_stuck_mot", 32'(motores), 32'd0);
        chk("t6_stuck_flt", 32'(fault),   32'd1);
        reset = 1'b1; tick(); reset = 1'b0;
        chk("t6_rst_flt", 32'(fault), 32'd0);
`else
        // Without the watchdog a long move never faults
        press(4'b0100);
        tick();
        ticks(200);
        chk("t6_nowd_mot", 32'(motores), 32'd1);
        chk("t6_nowd_flt", 32'(fault),   32'd0);
        reset = 1'b1; tick(); reset = 1'b0;
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
